// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the NTT data-memory loader, controller and unloader.
//   BN             - number of memory banks, which is also the row length
//   ADDR_W         - default per-bank write address width
//   loader_state_e - coefficient loader FSM states
package ntt_pkg;

  localparam int unsigned D_WIDTH_DEF = 32;
  localparam int unsigned BN          = 16;
  localparam int unsigned MA_DEF      = 64;
  localparam int unsigned ADDR_W      = $clog2(MA_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/mod_reduce.sv
// mod_reduce: combinational single conditional subtract into [0, modulus).
//   value_i   - raw value
//   modulus_i - reduction modulus
//   result_o  - value_i, value_i - modulus_i, or 0 when value_i >= 2*modulus_i
//   err_o     - high when value_i >= 2*modulus_i (cannot be reduced by one subtract)
module mod_reduce #(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic [D_WIDTH-1:0] value_i,
  input  logic [D_WIDTH-1:0] modulus_i,
  output logic [D_WIDTH-1:0] result_o,
  output logic               err_o
);

  // One extra bit so 2*modulus never overflows the compare.
  logic [D_WIDTH:0] val_x;
  logic [D_WIDTH:0] mod_x;
  logic [D_WIDTH:0] mod2_x;

  always_comb begin
    val_x    = {1'b0, value_i};
    mod_x    = {1'b0, modulus_i};
    mod2_x   = {modulus_i, 1'b0};
    result_o = value_i;
    err_o    = 1'b0;
    if (val_x >= mod2_x) begin
      result_o = '0;
      err_o    = 1'b1;
    end else if (val_x >= mod_x) begin
      result_o = value_i - modulus_i;
    end
  end

endmodule

// File: rtl/ntt_coef_loader.sv
// ntt_coef_loader: streams coefficients into the BN-bank NTT data memory.
// Each accepted coefficient is reduced mod `modulus` and packed into a row
// buffer; every BN coefficients the row is written to all banks at once, so
// coefficient n lands in bank n%BN at address n/BN.
//   clk, rst        - clock, asynchronous active-low reset
//   start           - begin a load (honoured only when idle)
//   modulus         - reduction modulus, stable while busy
//   in_valid/in_data/in_ready - coefficient stream
//   mem_wr_en/mem_wr_addr/mem_wr_data - row write to all banks
//   busy            - load in progress (FILL/WRITE)
//   load_done       - one-cycle pulse after the last row is written
//   range_err       - sticky: some input was >= 2*modulus
module ntt_coef_loader #(
  parameter int unsigned D_WIDTH = ntt_pkg::D_WIDTH_DEF,
  parameter int unsigned BN      = ntt_pkg::BN,
  parameter int unsigned MA      = ntt_pkg::MA_DEF,
  parameter int unsigned ADDR_W  = $clog2(MA)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [D_WIDTH-1:0]    modulus,
  input  logic                  in_valid,
  input  logic [D_WIDTH-1:0]    in_data,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [BN*D_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  range_err
);

  import ntt_pkg::loader_state_e;
  import ntt_pkg::IDLE;
  import ntt_pkg::FILL;
  import ntt_pkg::WRITE;
  import ntt_pkg::DONE;

  localparam int unsigned         COL_W    = (BN > 1) ? $clog2(BN) : 1;
  localparam logic [COL_W-1:0]    COL_LAST = COL_W'(BN - 1);
  localparam logic [ADDR_W-1:0]   ROW_LAST = ADDR_W'(MA - 1);

  loader_state_e       state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [D_WIDTH-1:0]  row_buf_q [BN];
  logic [D_WIDTH-1:0]  row_buf_d [BN];
  logic                range_err_q, range_err_d;
  logic                wr_en_q, wr_en_d;

  logic [D_WIDTH-1:0]  red_data;
  logic                red_err;

  mod_reduce #(
    .D_WIDTH (D_WIDTH)
  ) u_reduce (
    .value_i   (in_data),
    .modulus_i (modulus),
    .result_o  (red_data),
    .err_o     (red_err)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    row_buf_d   = row_buf_q;
    range_err_d = range_err_q;
    wr_en_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FILL;
          col_d       = '0;
          row_d       = '0;
          range_err_d = 1'b0;
        end
      end

      FILL: begin
        if (in_valid) begin
          row_buf_d[col_q] = red_data;
          if (red_err) begin
            range_err_d = 1'b1;
          end
          if (col_q == COL_LAST) begin
            // Row buffer and address registers feed the memory port directly;
            // raising the write strobe here makes all three valid in WRITE.
            col_d   = '0;
            state_d = WRITE;
            wr_en_d = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      WRITE: begin
        if (row_q == ROW_LAST) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = FILL;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      range_err_q <= 1'b0;
      wr_en_q     <= 1'b0;
      for (int unsigned i = 0; i < BN; i++) begin
        row_buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      range_err_q <= range_err_d;
      wr_en_q     <= wr_en_d;
      for (int unsigned i = 0; i < BN; i++) begin
        row_buf_q[i] <= row_buf_d[i];
      end
    end
  end

  always_comb begin
    mem_wr_data = '0;
    for (int unsigned b = 0; b < BN; b++) begin
      mem_wr_data[b*D_WIDTH +: D_WIDTH] = row_buf_q[b];
    end
  end

  assign in_ready    = (state_q == FILL);
  assign busy        = (state_q == FILL) || (state_q == WRITE);
  assign load_done   = (state_q == DONE);
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = row_q;
  assign range_err   = range_err_q;

endmodule

// File: tb/tb_ntt_coef_loader.sv
// tb_ntt_coef_loader: randomized scoreboard bench for ntt_coef_loader.
// The driver pushes the expected row write for every completed row; a monitor
// on the memory port pops and compares, and keeps a copy of the banks.
module tb_ntt_coef_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned BN = 16;
  localparam int unsigned MA = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned W  = BN * DW;
  localparam longint unsigned M = 65537;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] modulus;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [W-1:0]  mem_wr_data;
  logic          busy;
  logic          load_done;
  logic          range_err;

  ntt_coef_loader #(
    .D_WIDTH (DW),
    .BN      (BN),
    .MA      (MA),
    .ADDR_W  (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .modulus     (modulus),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .load_done   (load_done),
    .range_err   (range_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] exp_mem [BN][MA];
  logic [DW-1:0] mem     [BN][MA];
  bit            exp_err;
  int            done_cnt = 0;
  int            start_cyc;
  int            done_cyc;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference reduction straight from the arithmetic rule.
  function automatic logic [DW-1:0] ref_reduce(input longint unsigned x, output bit err);
    err = 1'b0;
    if (x < M) return DW'(x);
    if (x < 2 * M) return DW'(x - M);
    err = 1'b1;
    return '0;
  endfunction

  // Monitor: memory-side scoreboard plus bank image.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_t e;
      check("ready_low_in_write", W'(in_ready), W'(0));
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d expected no write", mem_wr_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", W'(mem_wr_addr), W'(e.addr));
        check("wr_data", mem_wr_data, e.data);
      end
      for (int b = 0; b < BN; b++) mem[b][mem_wr_addr] = mem_wr_data[b*DW +: DW];
    end
    if (load_done) done_cnt++;
  end

  // Driver. mode 0: n, mode 1: random in [0,2M), mode 2: boundary values then random in [0,3M].
  task automatic send_load(input int mode, input int gap_pct, input int start_at, input int abort_at);
    longint unsigned x;
    logic [DW-1:0]   r;
    logic [W-1:0]    row_acc;
    bit              e;
    int              waitc;
    longint unsigned special [4];
    special[0] = M; special[1] = M - 1; special[2] = 2 * M - 1; special[3] = 2 * M;
    row_acc = '0;
    for (int n = 0; n < int'(BN * MA); n++) begin
      if (mode == 0) x = longint'(n);
      else if (mode == 1) x = longint'($urandom_range(0, 2 * 65537 - 1));
      else if (n < 4) x = special[n];
      else x = longint'($urandom_range(0, 3 * 65537));
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      if (n == abort_at) begin
        in_valid = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_data  = DW'(x);
      waitc = 0;
      while (!in_ready) begin
        @(negedge clk);
        waitc++;
        if (waitc > 50) begin
          bound_fail("in_ready_wait");
          in_valid = 1'b0;
          return;
        end
      end
      if (n == start_at) start = 1'b1;
      r = ref_reduce(x, e);
      exp_err |= e;
      exp_mem[n % BN][n / BN] = r;
      row_acc[(n % BN) * DW +: DW] = r;
      if ((n % BN) == BN - 1) exp_q.push_back('{addr: AW'(n / BN), data: row_acc});
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
    exp_err   = 1'b0;
    done_cnt  = 0;
    check("start_in_ready", W'(in_ready), W'(1));
    check("start_busy", W'(busy), W'(1));
    check("start_range_err_clear", W'(range_err), W'(0));
  endtask

  task automatic wait_done();
    int waitc = 0;
    while (!load_done) begin
      @(negedge clk);
      waitc++;
      if (waitc > 100) begin
        bound_fail("load_done_wait");
        return;
      end
    end
    done_cyc = cyc;
  endtask

  task automatic finish_load(input bit timed);
    wait_done();
    // Start edge to DONE is MA rows of BN beats plus one write bubble.
    if (timed) check("done_latency", W'(done_cyc - start_cyc), W'(MA * (BN + 1)));
    repeat (3) @(negedge clk);
    check("done_once", W'(done_cnt), W'(1));
    check("busy_after", W'(busy), W'(0));
    check("range_err", W'(range_err), W'(exp_err));
    check("queue_drained", W'(exp_q.size()), W'(0));
    for (int b = 0; b < int'(BN); b++)
      for (int a = 0; a < int'(MA); a++)
        check($sformatf("mem_b%0d_a%0d", b, a), W'(mem[b][a]), W'(exp_mem[b][a]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; modulus = DW'(M);
    for (int b = 0; b < int'(BN); b++)
      for (int a = 0; a < int'(MA); a++) mem[b][a] = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_wr_en", W'(mem_wr_en), W'(0));
    check("rst_wr_addr", W'(mem_wr_addr), W'(0));
    check("rst_wr_data", mem_wr_data, '0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_load_done", W'(load_done), W'(0));
    check("rst_range_err", W'(range_err), W'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Sequential load, continuous valid.
    do_start();
    send_load(0, 0, -1, -1);
    finish_load(1'b1);
    check("bank3_addr2", W'(mem[3][2]), W'(35));

    // Reduction boundaries, then a back-to-back start in the cycle after load_done.
    do_start();
    send_load(2, 0, -1, -1);
    wait_done();
    check("red_done_latency", W'(done_cyc - start_cyc), W'(MA * (BN + 1)));
    @(negedge clk);
    check("range_err_sticky", W'(range_err), W'(1));
    check("red_65537", W'(mem[0][0]), W'(0));
    check("red_65536", W'(mem[1][0]), W'(65536));
    check("red_131073", W'(mem[2][0]), W'(65536));
    check("red_131074", W'(mem[3][0]), W'(0));
    do_start();
    send_load(1, 0, -1, -1);
    finish_load(1'b1);

    // Backpressure: same data as the sequential load, random gaps.
    do_start();
    send_load(0, 30, -1, -1);
    finish_load(1'b0);

    // Start pulse during row 5 must be ignored.
    do_start();
    send_load(1, 0, 5 * BN + 3, -1);
    finish_load(1'b1);

    // Reset during row 3 col 7, then a clean reload.
    do_start();
    send_load(1, 0, -1, 3 * BN + 7);
    rst = 1'b0;
    #1;
    check("arst_in_ready", W'(in_ready), W'(0));
    check("arst_wr_en", W'(mem_wr_en), W'(0));
    check("arst_wr_addr", W'(mem_wr_addr), W'(0));
    check("arst_wr_data", mem_wr_data, '0);
    check("arst_busy", W'(busy), W'(0));
    check("arst_load_done", W'(load_done), W'(0));
    check("arst_range_err", W'(range_err), W'(0));
    check("arst_queue", W'(exp_q.size()), W'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    do_start();
    send_load(1, 0, -1, -1);
    finish_load(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
